dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Multi-cycle data-memory sequencer between the single-cycle decode/control logic and a handshaked data-memory port.
- Detects load/store opcodes and stalls the PC and register write until the memory acknowledges.
- Generates byte enables and store-data lane replication, and returns sign/zero-extended load data.
- Lets the core use memories with variable latency in place of an ideal combinational data memory.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in REQ waiting for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  instruction opcode class, core encoding
- addr  in  32  effective address (ALU result)
- st_data  in  32  store source (rs2 read data)
- mem_ack  in  1  memory completed current request
- mem_rdata  in  32  memory read word, valid with mem_ack
- stall  out  1  hold PC and suppress all architectural writes
- ld_data  out  32  formatted load result for register write-back
- ld_we  out  1  load result valid, commit register write
- mem_req  out  1  request valid
- mem_we  out  1  1 = store, 0 = load
- mem_be  out  4  byte enables
- mem_addr  out  32  word address, {addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- bus_err  out  1  one-cycle pulse, access aborted by timeout

Behaviour:
- Opcode map:
  - Loads: LB 010000, LH 010001, LW 010010, LBU 010100, LHU 010101.
  - Stores: SB 110000, SH 110001, SW 110010.
  - Any other op is non-memory and is ignored.
- States are IDLE, REQ and DONE.
- Reset (async, immediate): state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ld_data=0, ld_we=0, bus_err=0, timeout counter=0.
- IDLE:
  - stall = is_mem(op), combinational.
  - On a memory op, op, addr[1:0], mem_addr, mem_be, mem_wdata and mem_we are registered at the clock edge; next state is REQ.
  - Non-memory ops: stall=0 and the state stays IDLE.
- REQ:
  - mem_req=1 and stall=1.
  - All request outputs are held stable; op, addr and st_data inputs are ignored.
  - mem_ack=1: capture mem_rdata, next state DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack (TIMEOUT_CYCLES>0): next state DONE with the abort flag set.
- DONE (exactly one cycle):
  - stall=0 and mem_req=0.
  - Loads: ld_we=1 and ld_data is the formatted captured word.
  - Stores: ld_we=0.
  - Abort: ld_we=0, ld_data=0, bus_err=1.
  - Next state is IDLE. The PC advances at the end of DONE, so the same instruction is not re-detected.
- Minimum memory-instruction latency is 3 cycles (IDLE, REQ, DONE) with ack in the first REQ cycle.
- Byte enables:
  - SB / byte loads: mem_be = 4'b0001 << addr[1:0].
  - SH / half loads: mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: mem_be = 4'b1111.
  - Loads drive the same enables as the equivalent store.
- Store data:
  - SB: {4{st_data[7:0]}}.
  - SH: {2{st_data[15:0]}}.
  - SW: st_data.
- Load formatting:
  - Byte loads select lane addr[1:0]; half loads select half addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Misaligned addresses with MISALIGN_TRAP_EN undefined:
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - The access proceeds normally.
- ld_data and ld_we are 0 in every state except DONE.
- mem_ack is ignored outside REQ.
- Reset asserted in REQ drops mem_req in the same cycle, with no completion.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - A memory op in IDLE with misaligned addr goes IDLE→DONE with no memory request; mem_req is never asserted.
  - In DONE: misalign=1 for one cycle, ld_we=0, ld_data=0, and no store occurs.
  - Misaligned means: half access with addr[0]=1, or word access with addr[1:0]≠0.
- Undefined: no misalign port; the aligning behaviour described in Behaviour applies.

Test Plan:
- LB, addr=0x103, mem_rdata=0x80AA_BBCC, ack in first REQ cycle → mem_be=1000, mem_addr=0x100, DONE on cycle 3 with ld_data=0xFFFF_FF80, ld_we=1.
- SH, addr=0x202, st_data=0x1234_5678, ack after 4 cycles → mem_we=1, mem_be=1100, mem_wdata=0x5678_5678, stall=1 for 5 cycles, ld_we=0.
- LHU, addr=0x10, mem_rdata=0xDEAD_BEEF, ack after 2 cycles → ld_data=0x0000_BEEF; op change during REQ does not alter mem_addr/mem_be.
- No ack with TIMEOUT_CYCLES=16 → mem_req high for 16 cycles, then bus_err=1 for one cycle, ld_we=0, stall released.
- rst pulsed mid-REQ → mem_req=0 immediately, state IDLE, no ld_we pulse; a later LW completes normally.
- MISALIGN_TRAP_EN defined, LW addr=0x6 → mem_req never asserted, misalign=1 on cycle 2, ld_we=0.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Handshaked data-memory port between dmem_access_ctrl (master) and the data memory (slave).
interface dmem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store sequencer (IDLE -> REQ -> DONE) in front of a variable-latency data memory.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses skip the memory and raise a one-cycle misalign pulse.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_we,
  output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  dmem_access_ctrl_if.master mem
);

  localparam logic [5:0] OP_LB  = 6'b010000;
  localparam logic [5:0] OP_LH  = 6'b010001;
  localparam logic [5:0] OP_LW  = 6'b010010;
  localparam logic [5:0] OP_LBU = 6'b010100;
  localparam logic [5:0] OP_LHU = 6'b010101;
  localparam logic [5:0] OP_SB  = 6'b110000;
  localparam logic [5:0] OP_SH  = 6'b110001;
  localparam logic [5:0] OP_SW  = 6'b110010;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [5:0]       op_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      rdata_q;
  logic             abort_q;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
`ifdef MISALIGN_TRAP_EN
  logic             mis_now;
  logic             mis_q;
`endif

  function automatic logic is_mem_op(input logic [5:0] o);
    return o inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_load_op(input logic [5:0] o);
    return o inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  // Access size lives in op[1:0] for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] byte_en(input logic [5:0] o, input logic [1:0] lo);
    case (o[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [5:0] o, input logic [31:0] d);
    case (o[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [5:0] o, input logic [1:0] lo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (o)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign mis_now = ((op[1:0] == 2'b01) && addr[0]) ||
                   ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`endif

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    mem.mem_req = 1'b0;
    ld_we       = 1'b0;
    ld_data     = 32'h0;
    bus_err     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        stall = is_mem_op(op);
        if (is_mem_op(op)) begin
`ifdef MISALIGN_TRAP_EN
          state_nxt = mis_now ? S_DONE : S_REQ;
`else
          state_nxt = S_REQ;
`endif
        end
      end
      S_REQ: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ack || timeout_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        if (abort_q) begin
          bus_err = 1'b1;
`ifdef MISALIGN_TRAP_EN
        end else if (mis_q) begin
          misalign = 1'b1;
`endif
        end else if (is_load_op(op_q)) begin
          ld_we   = 1'b1;
          ld_data = format_load(op_q, addr_lo_q, rdata_q);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields are frozen when the op is accepted so REQ ignores the (possibly changing) core inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= 6'h0;
      addr_lo_q     <= 2'b00;
      rdata_q       <= 32'h0;
      abort_q       <= 1'b0;
      cnt           <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= 4'h0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      mis_q         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mem_op(op)) begin
            op_q          <= op;
            addr_lo_q     <= addr[1:0];
            abort_q       <= 1'b0;
            cnt           <= '0;
            mem.mem_we    <= !is_load_op(op);
            mem.mem_be    <= byte_en(op, addr[1:0]);
            mem.mem_addr  <= {addr[31:2], 2'b00};
            mem.mem_wdata <= store_lanes(op, st_data);
`ifdef MISALIGN_TRAP_EN
            mis_q         <= mis_now;
`endif
          end
        end
        S_REQ: begin
          if (mem.mem_ack) begin
            rdata_q <= mem.mem_rdata;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (timeout_hit) abort_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
